// File: rtl/axi_xbar_pkg.sv
// Shared crossbar types: B-channel response codes, default widths and the packed B entry.
// Also carries small elaboration helpers used by the response-path blocks.
package axi_xbar_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   localparam int unsigned DEF_ID_WIDTH   = 4;
   localparam int unsigned DEF_RESP_WIDTH = 2;
   localparam int unsigned DEF_USER_WIDTH = 1;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0]   id;
      logic [DEF_RESP_WIDTH-1:0] resp;
      logic [DEF_USER_WIDTH-1:0] user;
   } b_entry_t;

   // A zero-width sideband still occupies one (ignored) bit on the ports.
   function automatic int unsigned eff_width(input int unsigned w);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic logic is_pow2(input int unsigned v);
      return 1'((v != 0) && ((v & (v - 1)) == 0));
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer and occupancy control for a power-of-two FIFO.
// Occupancy, not pointer equality, decides full and empty.
module fifo_ptr_ctrl #(
   parameter  int unsigned DEPTH    = 4,
   parameter  int unsigned AF_LEVEL = DEPTH - 1,
   localparam int unsigned PW       = $clog2(DEPTH),
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          wr_req_i,
   input  logic          rd_req_i,
   output logic          push_o,
   output logic          pop_o,
   output logic [PW-1:0] rd_ptr_o,
   output logic [PW-1:0] wr_ptr_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          almost_full_o
);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          af_q, af_d;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign push_o  = wr_req_i & ~full_o;
   assign pop_o   = rd_req_i & ~empty_o;

   // Next-state: pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_o) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_o)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_o, pop_o})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      af_d = (count_d >= CW'(AF_LEVEL));
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         af_q     <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         af_q     <= af_d;
      end
   end

   assign rd_ptr_o      = rd_ptr_q;
   assign wr_ptr_o      = wr_ptr_q;
   assign count_o       = count_q;
   assign almost_full_o = af_q;

endmodule

// File: rtl/axi_resp_fifo.sv
// AXI B-channel response FIFO between a slave return port and a master B channel.
// Optional zero-latency empty bypass is enabled by defining AXI_RESP_FIFO_BYPASS_EN.
module axi_resp_fifo
   import axi_xbar_pkg::*;
#(
   parameter  int unsigned DEPTH      = 4,
   parameter  int unsigned ID_WIDTH   = DEF_ID_WIDTH,
   parameter  int unsigned RESP_WIDTH = DEF_RESP_WIDTH,
   parameter  int unsigned USER_WIDTH = 0,
   parameter  int unsigned AF_LEVEL   = DEPTH - 1,
   localparam int unsigned UW         = eff_width(USER_WIDTH),
   localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ID_WIDTH-1:0]   s_BID,
   input  logic [RESP_WIDTH-1:0] s_BRESP,
   input  logic [UW-1:0]         s_BUSER,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [ID_WIDTH-1:0]   m_BID,
   output logic [RESP_WIDTH-1:0] m_BRESP,
   output logic [UW-1:0]         m_BUSER,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CW-1:0]         count,
   output logic                  almost_full
);

   localparam int unsigned EW = ID_WIDTH + RESP_WIDTH + UW;
   localparam int unsigned PW = $clog2(DEPTH);

   if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
      $error("axi_resp_fifo: DEPTH must be a power of two and at least 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("axi_resp_fifo: AF_LEVEL must lie in 1..DEPTH");
   end

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] wr_entry_c;
   logic [EW-1:0] head_c;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          push, pop, full, empty;
   logic          bypass_c, wr_req_c;

   // A zero-width user field is stored as a constant zero.
   assign wr_entry_c = {s_BID, s_BRESP, (USER_WIDTH == 0) ? UW'(0) : s_BUSER};

`ifdef AXI_RESP_FIFO_BYPASS_EN
   assign bypass_c = empty & s_valid & m_ready;
   assign m_valid  = ~empty | s_valid;
   assign head_c   = empty ? wr_entry_c : mem_q[rd_ptr];
`else
   assign bypass_c = 1'b0;
   assign m_valid  = ~empty;
   assign head_c   = mem_q[rd_ptr];
`endif

   // A bypassed entry is consumed on the spot and never written.
   assign wr_req_c = s_valid & ~bypass_c;
   assign s_ready  = ~full;

   fifo_ptr_ctrl #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
   ) u_ptr_ctrl (
      .clk_i         (ACLK),
      .rst_ni        (ARESETn),
      .wr_req_i      (wr_req_c),
      .rd_req_i      (m_ready),
      .push_o        (push),
      .pop_o         (pop),
      .rd_ptr_o      (rd_ptr),
      .wr_ptr_o      (wr_ptr),
      .count_o       (count),
      .full_o        (full),
      .empty_o       (empty),
      .almost_full_o (almost_full)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr] <= wr_entry_c;
      end
   end

   assign m_BID   = head_c[EW-1 -: ID_WIDTH];
   assign m_BRESP = head_c[UW +: RESP_WIDTH];
   assign m_BUSER = head_c[UW-1:0];

   a_svalid_hold: assert property (@(posedge ACLK) disable iff (!ARESETn)
      (s_valid && !s_ready) |=> s_valid);
   a_no_x_ctrl: assert property (@(posedge ACLK) disable iff (!ARESETn)
      !$isunknown({s_valid, m_ready}));
   a_pop_valid: assert property (@(posedge ACLK) disable iff (!ARESETn)
      pop |-> m_valid);

endmodule
